// File: rtl/mem_responder.sv
// mem_responder: byte-addressed, big-endian memory responder on the CPU memory-address path.
// Accepts one request at a time, stalls WAIT_CYCLES cycles, then answers with a one-cycle pulse.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] idx [4];
  logic [7:0]        rd_byte [4];
  logic [7:0]        byte_data [4];
  logic [3:0]        byte_we;
  logic              access_err;
  logic [31:0]       load_data;

  // Byte k of an access lives at addr+k; lane 0 is the most significant (big-endian).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]     = addr_q[ADDR_W-1:0] + ADDR_W'(k);
      rd_byte[k] = mem_q[idx[k]];
    end
  end

  always_comb begin
    access_err = 1'b0;
    if ((addr_q >> ADDR_W) != 32'd0) begin
      access_err = 1'b1;
    end
    case (size_q)
      2'b00:   access_err = access_err;
      2'b01:   access_err = access_err | addr_q[0];
      2'b10:   access_err = access_err | (addr_q[1:0] != 2'b00);
      default: access_err = 1'b1;
    endcase
  end

  always_comb begin
    load_data = 32'd0;
    case (size_q)
      2'b00:   load_data = {24'd0, rd_byte[0]};
      2'b01:   load_data = {16'd0, rd_byte[0], rd_byte[1]};
      2'b10:   load_data = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      default: load_data = 32'd0;
    endcase
  end

  // Store data is right-justified on the request, so the top active byte goes to the lowest address.
  always_comb begin
    byte_we = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      byte_data[k] = 8'h00;
    end
    if (state_q == ST_ACCESS && write_q && !access_err) begin
      case (size_q)
        2'b00: begin
          byte_we      = 4'b0001;
          byte_data[0] = wdata_q[7:0];
        end
        2'b01: begin
          byte_we      = 4'b0011;
          byte_data[0] = wdata_q[15:8];
          byte_data[1] = wdata_q[7:0];
        end
        2'b10: begin
          byte_we      = 4'b1111;
          byte_data[0] = wdata_q[31:24];
          byte_data[1] = wdata_q[23:16];
          byte_data[2] = wdata_q[15:8];
          byte_data[3] = wdata_q[7:0];
        end
        default: byte_we = 4'b0000;
      endcase
    end
  end

  // Storage keeps its contents across reset; only the ACCESS state can write it.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (byte_we[k]) begin
        mem_q[idx[k]] <= byte_data[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        err_d   = access_err;
        rdata_d = (access_err || write_q) ? 32'd0 : load_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (WAIT_CYCLES 3 and 0) checked against a
// byte-array reference model; directed scenarios followed by randomized transactions.
module tb_mem_responder;

  localparam int W0 = 3;
  localparam int W1 = 0;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [1:0]  req_valid, req_write;
  logic [1:0]  req_size [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];

  logic        ready0, ready1, valid0, valid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rdy_v, rspv_v, err_v;
  logic [31:0] rdata_v [2];

  assign rdy_v      = {ready1, ready0};
  assign rspv_v     = {valid1, valid0};
  assign err_v      = {err1, err0};
  assign rdata_v[0] = rdata0;
  assign rdata_v[1] = rdata1;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(ready0), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_err(err0)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(ready1), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(valid1), .rsp_rdata(rdata1), .rsp_err(err1)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mem_m [2][256];

  function automatic int wait_of(input int s);
    return (s == 0) ? W0 : W1;
  endfunction

  // The pulse occupies the cycle closing at accept edge + W + 2, i.e. it is first
  // visible just after edge W + 1 counted from the accepting edge.
  function automatic int lat_exp(input int s);
    return wait_of(s) + 1;
  endfunction

  function automatic void model_txn(input int s, input bit wr, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rd, output logic er);
    int n, a;
    n  = 1 << size;
    er = (size == 2'b11) || ((int'(addr[2:0]) % n) != 0) || (addr >= 32'd256);
    rd = 32'd0;
    if (!er) begin
      a = int'(addr[7:0]);
      for (int i = 0; i < n; i++) begin
        if (wr) mem_m[s][a+i] = wdata[8*(n-1-i) +: 8];
        else    rd = {rd[23:0], mem_m[s][a+i]};
      end
    end
  endfunction

  task automatic wait_ready(input int s);
    int guard = 0;
    @(negedge clock);
    while (rdy_v[s] !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
  endtask

  task automatic txn(input int s, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                     output int lat, output logic [31:0] exp_rd, output logic exp_er);
    model_txn(s, wr, size, addr, wdata, exp_rd, exp_er);
    wait_ready(s);
    req_write[s] = wr;
    req_size[s]  = size;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_valid[s] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid[s] = 1'b0;
    lat = -1;
    rd  = 'x;
    er  = 'x;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (rspv_v[s] === 1'b1) begin
        lat = e;
        rd  = rdata_v[s];
        er  = err_v[s];
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    for (int s = 0; s < 2; s++) begin
      req_size[s]  = 2'b00;
      req_addr[s]  = 32'd0;
      req_wdata[s] = 32'd0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if ({rdy_v[s], rspv_v[s], err_v[s], rdata_v[s]} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        miscompares++;
        $display("[TB] FAIL reset_in s=%0d: got rdy=%b v=%b err=%b rd=%h expected 1 0 0 00000000",
                 s, rdy_v[s], rspv_v[s], err_v[s], rdata_v[s]);
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if ({rdy_v[s], rspv_v[s], err_v[s], rdata_v[s]} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        miscompares++;
        $display("[TB] FAIL reset_idle s=%0d: got rdy=%b v=%b err=%b rd=%h expected 1 0 0 00000000",
                 s, rdy_v[s], rspv_v[s], err_v[s], rdata_v[s]);
      end
    end
  endtask

  task automatic test_init;
    logic [31:0] rd, xr;
    logic er, xe;
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 64; w++) begin
        txn(s, 1'b1, 2'b10, 32'(w * 4), $urandom, rd, er, lat, xr, xe);
        vectors++;
        if (er !== 1'b0 || rd !== 32'd0 || lat != lat_exp(s)) begin
          miscompares++;
          $display("[TB] FAIL init_store s=%0d w=%0d: got err=%b rd=%h lat=%0d expected 0 00000000 %0d",
                   s, w, er, rd, lat, lat_exp(s));
        end
      end
    end
  endtask

  task automatic test_word;
    logic [31:0] rd, xr;
    logic er, xe;
    int lat;
    for (int s = 0; s < 2; s++) begin
      txn(s, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er, lat, xr, xe);
      vectors++;
      if (er !== 1'b0 || lat != lat_exp(s)) begin
        miscompares++;
        $display("[TB] FAIL word_store s=%0d: got err=%b lat=%0d expected 0 %0d", s, er, lat, lat_exp(s));
      end
      txn(s, 1'b0, 2'b10, 32'h10, 32'd0, rd, er, lat, xr, xe);
      vectors++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != lat_exp(s)) begin
        miscompares++;
        $display("[TB] FAIL word_load s=%0d: got rd=%h err=%b lat=%0d expected deadbeef 0 %0d",
                 s, rd, er, lat, lat_exp(s));
      end
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd, xr;
    logic er, xe;
    int lat;
    for (int s = 0; s < 2; s++) begin
      txn(s, 1'b1, 2'b10, 32'h20, 32'h11223344, rd, er, lat, xr, xe);
      txn(s, 1'b1, 2'b00, 32'h20, 32'h000000AA, rd, er, lat, xr, xe);
      txn(s, 1'b1, 2'b00, 32'h23, 32'hFFFFFFBB, rd, er, lat, xr, xe);
      txn(s, 1'b0, 2'b10, 32'h20, 32'd0, rd, er, lat, xr, xe);
      vectors++;
      if (rd !== 32'hAA2233BB || er !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL byte_merge s=%0d: got rd=%h err=%b expected aa2233bb 0", s, rd, er);
      end
      txn(s, 1'b0, 2'b01, 32'h22, 32'd0, rd, er, lat, xr, xe);
      vectors++;
      if (rd !== 32'h000033BB || er !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL half_load s=%0d: got rd=%h err=%b expected 000033bb 0", s, rd, er);
      end
    end
  endtask

  task automatic test_vector_byte;
    logic [31:0] rd, xr;
    logic er, xe;
    int lat;
    for (int s = 0; s < 2; s++) begin
      txn(s, 1'b1, 2'b00, 32'd253, 32'h00000040, rd, er, lat, xr, xe);
      txn(s, 1'b0, 2'b00, 32'd253, 32'd0, rd, er, lat, xr, xe);
      vectors++;
      if (rd !== 32'h00000040 || er !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL vector_byte s=%0d: got rd=%h err=%b expected 00000040 0", s, rd, er);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, xr;
    logic er, xe;
    int lat;
    bit          wr_t [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  size_t [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] addr_t [4] = '{32'h02, 32'h05, 32'h08, 32'h100};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        txn(s, wr_t[i], size_t[i], addr_t[i], 32'hFFFFFFFF, rd, er, lat, xr, xe);
        vectors++;
        if (er !== 1'b1 || rd !== 32'd0 || lat != lat_exp(s)) begin
          miscompares++;
          $display("[TB] FAIL err_case%0d s=%0d: got err=%b rd=%h lat=%0d expected 1 00000000 %0d",
                   i, s, er, rd, lat, lat_exp(s));
        end
      end
      for (int a = 0; a < 12; a += 4) begin
        txn(s, 1'b0, 2'b10, 32'(a), 32'd0, rd, er, lat, xr, xe);
        vectors++;
        if (rd !== xr || er !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL err_reread s=%0d a=%0d: got rd=%h err=%b expected %h 0", s, a, rd, er, xr);
        end
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] ra, rb;
    logic de;
    int acc2, w;
    int rsp_edge[$];
    logic [31:0] rsp_data[$];
    for (int s = 0; s < 2; s++) begin
      w = wait_of(s);
      model_txn(s, 1'b0, 2'b10, 32'h40, 32'd0, ra, de);
      model_txn(s, 1'b0, 2'b10, 32'h44, 32'd0, rb, de);
      rsp_edge.delete();
      rsp_data.delete();
      acc2 = -1;
      wait_ready(s);
      req_write[s] = 1'b0;
      req_size[s]  = 2'b10;
      req_addr[s]  = 32'h40;
      req_valid[s] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_addr[s] = 32'h44;
      for (int e = 1; e <= 2 * (w + 3) + 4; e++) begin
        if (e > 1) @(negedge clock);
        if (acc2 < 0 && rdy_v[s] === 1'b1) acc2 = e;
        @(posedge clock);
        #1;
        if (rspv_v[s] === 1'b1) begin
          rsp_edge.push_back(e);
          rsp_data.push_back(rdata_v[s]);
        end
        if (acc2 == e) req_valid[s] = 1'b0;
      end
      req_valid[s] = 1'b0;
      vectors++;
      if (acc2 != w + 3) begin
        miscompares++;
        $display("[TB] FAIL hold_accept s=%0d: got edge %0d expected %0d", s, acc2, w + 3);
      end
      vectors++;
      if (rsp_edge.size() != 2) begin
        miscompares++;
        $display("[TB] FAIL hold_count s=%0d: got %0d pulses expected 2", s, rsp_edge.size());
      end else begin
        vectors++;
        if (rsp_edge[0] != w + 1 || rsp_data[0] !== ra) begin
          miscompares++;
          $display("[TB] FAIL hold_first s=%0d: got edge %0d rd=%h expected %0d %h",
                   s, rsp_edge[0], rsp_data[0], w + 1, ra);
        end
        vectors++;
        if (rsp_edge[1] != 2 * w + 4 || rsp_data[1] !== rb) begin
          miscompares++;
          $display("[TB] FAIL hold_second s=%0d: got edge %0d rd=%h expected %0d %h",
                   s, rsp_edge[1], rsp_data[1], 2 * w + 4, rb);
        end
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, xr;
    logic er, xe;
    int lat;
    bit saw;
    txn(0, 1'b0, 2'b10, 32'h30, 32'd0, rd, er, lat, xr, xe);
    wait_ready(0);
    req_write[0] = 1'b1;
    req_size[0]  = 2'b10;
    req_addr[0]  = 32'h30;
    req_wdata[0] = ~xr;
    req_valid[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({rdy_v[0], rspv_v[0], err_v[0], rdata_v[0]} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs: got rdy=%b v=%b err=%b rd=%h expected 1 0 0 00000000",
               rdy_v[0], rspv_v[0], err_v[0], rdata_v[0]);
    end
    saw = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (rspv_v[0] === 1'b1) saw = 1'b1;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (W0 + 4) begin
      @(posedge clock);
      #1;
      if (rspv_v[0] === 1'b1) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_pulse: got rsp_valid=1 expected no pulse");
    end
    txn(0, 1'b0, 2'b10, 32'h30, 32'd0, rd, er, lat, xr, xe);
    vectors++;
    if (rd !== xr || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_reread: got rd=%h err=%b expected %h 0", rd, er, xr);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, xr, addr;
    logic er, xe;
    logic [1:0] size;
    bit wr;
    int lat, s;
    for (int i = 0; i < 80; i++) begin
      s    = i % 2;
      wr   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) size = 2'b11;
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << size) - 1);
      if ($urandom_range(0, 15) == 0) addr = addr | (32'd1 << $urandom_range(8, 31));
      txn(s, wr, size, addr, $urandom, rd, er, lat, xr, xe);
      vectors++;
      if (rd !== xr) begin
        miscompares++;
        $display("[TB] FAIL rand_rdata i=%0d s=%0d wr=%0d sz=%0d a=%h: got %h expected %h",
                 i, s, wr, size, addr, rd, xr);
      end
      vectors++;
      if (er !== xe) begin
        miscompares++;
        $display("[TB] FAIL rand_err i=%0d s=%0d sz=%0d a=%h: got %b expected %b", i, s, size, addr, er, xe);
      end
      vectors++;
      if (lat != lat_exp(s)) begin
        miscompares++;
        $display("[TB] FAIL rand_latency i=%0d s=%0d: got %0d expected %0d", i, s, lat, lat_exp(s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_word();
    test_byte_lanes();
    test_vector_byte();
    test_errors();
    test_hold();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
